// File: rtl/fft_frame_buffer.sv
// Streaming sample buffer that gathers FFT_POINTS-sample frames and hands them to a downstream FFT.
// Build macro FFT_FRAME_OVERLAP_EN selects 50% frame overlap; undefined gives back-to-back frames.
module fft_frame_buffer #(
  parameter int FFT_POINTS = 16,
  parameter int DATA_WIDTH = 24
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  input  logic                         sample_valid,
  input  logic                         fft_data_valid,
  output logic                         start_fft,
  output logic signed [DATA_WIDTH-1:0] frame_out [0:FFT_POINTS-1],
  output logic                         fft_busy,
  output logic                         frame_dropped,
  output logic [7:0]                   drop_count
);

  localparam int PTR_W = $clog2(FFT_POINTS);
  localparam int CNT_W = PTR_W + 1;
`ifdef FFT_FRAME_OVERLAP_EN
  localparam int HOP = FFT_POINTS / 2;
`else
  localparam int HOP = FFT_POINTS;
`endif
  localparam logic [PTR_W-1:0] HOP_LAST  = PTR_W'(HOP - 1);
  localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(FFT_POINTS);

  logic signed [DATA_WIDTH-1:0] buffer     [0:FFT_POINTS-1];
  logic signed [DATA_WIDTH-1:0] frame_next [0:FFT_POINTS-1];

  logic [PTR_W-1:0] wr_ptr, wr_ptr_next;
  logic [PTR_W-1:0] hop_cnt, hop_next;
  logic [CNT_W-1:0] fill_cnt, fill_next;
  logic             due, launch, drop;

  always_comb begin
    wr_ptr_next = wr_ptr + PTR_W'(1);
    hop_next    = (hop_cnt == HOP_LAST) ? '0 : hop_cnt + PTR_W'(1);
    fill_next   = (fill_cnt == FILL_FULL) ? fill_cnt : fill_cnt + CNT_W'(1);
    due         = sample_valid && (hop_cnt == HOP_LAST) && (fill_next == FILL_FULL);
    launch      = due && !fft_busy;
    // A due frame while busy is dropped even if the result returns this cycle.
    drop        = due && fft_busy;
  end

  // Oldest sample first; the entry being written this cycle is bypassed from sample_in.
  always_comb begin
    for (int k = 0; k < FFT_POINTS; k++) begin
      logic [PTR_W-1:0] idx;
      idx = wr_ptr_next + PTR_W'(k);
      frame_next[k] = (idx == wr_ptr) ? sample_in : buffer[idx];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all reads see pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr        <= '0;
      fill_cnt      <= '0;
      hop_cnt       <= '0;
      start_fft     <= 1'b0;
      fft_busy      <= 1'b0;
      frame_dropped <= 1'b0;
      drop_count    <= '0;
      // NOTE: the sample memory is cleared too, so stale pre-reset data can never reach a frame.
      for (int k = 0; k < FFT_POINTS; k++) begin
        buffer[k]    <= '0;
        frame_out[k] <= '0;
      end
    end else begin
      start_fft     <= launch;
      frame_dropped <= drop;
      if (sample_valid) begin
        buffer[wr_ptr] <= sample_in;
        wr_ptr         <= wr_ptr_next;
        fill_cnt       <= fill_next;
        hop_cnt        <= hop_next;
      end
      if (launch) begin
        frame_out <= frame_next;
        fft_busy  <= 1'b1;
      end else if (fft_data_valid) begin
        fft_busy <= 1'b0;
      end
      if (drop && drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed self-checking bench for fft_frame_buffer (FFT_POINTS=16, DATA_WIDTH=24).
// Overlap scenarios run when FFT_FRAME_OVERLAP_EN is defined, the no-overlap set otherwise.
module tb_fft_frame_buffer;

  localparam int N  = 16;
  localparam int DW = 24;

  logic                 clk = 1'b0;
  logic                 reset;
  logic signed [DW-1:0] sample_in;
  logic                 sample_valid;
  logic                 fft_data_valid;
  logic                 start_fft;
  logic signed [DW-1:0] frame_out [0:N-1];
  logic                 fft_busy;
  logic                 frame_dropped;
  logic [7:0]           drop_count;

  int checks_total  = 0;
  int checks_passed = 0;
  int launches      = 0;
  int drops         = 0;
  int base_launch;
  int base_drop;

  fft_frame_buffer #(.FFT_POINTS(N), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .fft_data_valid (fft_data_valid),
    .start_fft      (start_fft),
    .frame_out      (frame_out),
    .fft_busy       (fft_busy),
    .frame_dropped  (frame_dropped),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (start_fft)     launches++;
    if (frame_dropped) drops++;
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    sample_in    = DW'(v);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int first);
    for (int k = 0; k < N; k++)
      check($sformatf("%s[%0d]", tag, k), 32'(frame_out[k]), 32'(first + k));
  endtask

  task automatic release_fft();
    fft_data_valid = 1'b1;
    tick();
    fft_data_valid = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    sample_in      = '0;
    sample_valid   = 1'b0;
    fft_data_valid = 1'b0;
    do_reset();

    check("rst_start", start_fft, 0);
    check("rst_busy", fft_busy, 0);
    check("rst_drop_cnt", drop_count, 0);
    check("rst_frame0", 32'(frame_out[0]), 0);

    // Contiguous fill: launch exactly in the cycle after sample 16.
    base_launch = launches;
    for (int i = 1; i <= 15; i++) send(i);
    check("fill_no_early_start", start_fft, 0);
    send(16);
    check("fill_start", start_fft, 1);
    check("fill_busy", fft_busy, 1);
    check_frame("fill_frame", 1);
    tick();
    check("fill_start_one_cycle", start_fft, 0);
    check("fill_launch_count", 32'(launches - base_launch), 1);

`ifdef FFT_FRAME_OVERLAP_EN
    // 50% overlap: second frame after sample 24 holds 9..24.
    release_fft();
    check("ovl_busy_clear", fft_busy, 0);
    base_launch = launches;
    for (int i = 17; i <= 23; i++) send(i);
    check("ovl_no_early_start", 32'(launches - base_launch), 0);
    send(24);
    check("ovl_start", start_fft, 1);
    check_frame("ovl_frame", 9);
    release_fft();
`else
    // Busy drop: FFT result withheld while the next frame comes due.
    base_drop = drops;
    for (int i = 17; i <= 32; i++) send(i);
    check("drop_pulse", frame_dropped, 1);
    check("drop_cnt1", drop_count, 1);
    check_frame("drop_frame_held", 1);
    tick();
    check("drop_pulse_count", 32'(drops - base_drop), 1);
    release_fft();
    check("drop_busy_clear", fft_busy, 0);
    for (int i = 33; i <= 48; i++) send(i);
    check("relaunch_start", start_fft, 1);
    check_frame("relaunch_frame", 33);

    // Result returns in the same cycle the next frame comes due: still a drop.
    for (int i = 49; i <= 63; i++) send(i);
    fft_data_valid = 1'b1;
    send(64);
    fft_data_valid = 1'b0;
    check("sim_drop", frame_dropped, 1);
    check("sim_start", start_fft, 0);
    check("sim_busy", fft_busy, 0);
    check("sim_drop_cnt", drop_count, 2);
    check_frame("sim_frame_held", 33);
    for (int i = 65; i <= 80; i++) send(i);
    check("sim_next_start", start_fft, 1);
    check_frame("sim_next_frame", 65);

    // Gapped input with an idle-time result pulse that must be ignored.
    do_reset();
    release_fft();
    check("idle_dv_ignored", fft_busy, 0);
    base_launch = launches;
    for (int i = 1; i <= 16; i++) begin
      send(i);
      if (i == 16) check("gap_start", start_fft, 1);
      tick();
    end
    check("gap_launch_count", 32'(launches - base_launch), 1);
    check_frame("gap_frame", 1);
`endif

    // Reset mid-operation, with a sample presented during reset that must be ignored.
    for (int i = 200; i < 210; i++) send(i);
    sample_in    = DW'(999);
    sample_valid = 1'b1;
    do_reset();
    sample_valid = 1'b0;
    check("mid_rst_busy", fft_busy, 0);
    check("mid_rst_drop_cnt", drop_count, 0);
    check("mid_rst_frame15", 32'(frame_out[N-1]), 0);
    base_launch = launches;
    for (int i = 100; i <= 114; i++) send(i);
    check("mid_rst_no_early", 32'(launches - base_launch), 0);
    send(115);
    check("mid_rst_start", start_fft, 1);
    check_frame("mid_rst_frame", 100);
    check("mid_rst_drop_cnt_after", drop_count, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/fft_frame_buffer.md
FFT_FRAME_BUFFER -- requirements
Module: fft_frame_buffer

Interface
REQ-001 The block SHALL have parameter FFT_POINTS, default 16, meaning samples per frame; it SHALL be a power of two, minimum 4.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 24, meaning width of a signed two's-complement sample.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port sample_in, input, DATA_WIDTH bits: the streaming input sample.
REQ-006 The block SHALL have port sample_valid, input, 1 bit: sample_in is accepted on every cycle this is high.
REQ-007 The block SHALL have port fft_data_valid, input, 1 bit: pulse from the downstream FFT marking result completion.
REQ-008 The block SHALL have port start_fft, output, 1 bit: one-cycle launch pulse to the FFT.
REQ-009 The block SHALL have port frame_out, output, array [0:FFT_POINTS-1] of DATA_WIDTH bits: the frame presented to the FFT, index 0 oldest.
REQ-010 The block SHALL have port fft_busy, output, 1 bit: a frame is launched and its result is not yet returned.
REQ-011 The block SHALL have port frame_dropped, output, 1 bit: one-cycle pulse when a due frame is discarded.
REQ-012 The block SHALL have port drop_count, output, 8 bits: saturating count of dropped frames.

Function
REQ-013 Accepted samples SHALL be written to a circular buffer of FFT_POINTS entries at wr_ptr, and wr_ptr SHALL increment modulo FFT_POINTS.
REQ-014 A fill counter SHALL count accepted samples and saturate at FFT_POINTS; the buffer is primed once the counter reaches FFT_POINTS.
REQ-015 A hop counter SHALL count accepted samples from 0 to HOP-1 and wrap; a frame is due on the accept that wraps it while primed (counting that accept).
REQ-016 HOP SHALL equal FFT_POINTS, except as given in REQ-027.
REQ-017 On a due frame with fft_busy low, at the next edge the block SHALL register frame_out[k] = buffer[(wr_ptr_new + k) mod FFT_POINTS] for all k, where wr_ptr_new is the post-increment pointer.
REQ-018 In the same cycle as REQ-017, start_fft SHALL pulse high for exactly one cycle and fft_busy SHALL set.
REQ-019 Launch latency SHALL be one cycle: start_fft is high in the cycle after the edge that accepted the due sample.
REQ-020 The value written in that same edge SHALL appear in frame_out[FFT_POINTS-1] (bypass of the write).
REQ-021 frame_out SHALL hold stable from launch until the next launch, irrespective of further samples.
REQ-022 fft_busy SHALL clear on the edge where fft_data_valid is sampled high; fft_data_valid while idle SHALL be ignored.
REQ-023 A frame due while fft_busy is high SHALL be discarded: frame_dropped pulses one cycle, drop_count increments (saturating at 255), and frame_out is unchanged.
REQ-024 If fft_data_valid and a due frame occur in the same cycle, the frame SHALL be dropped, since busy clears at that same edge.
REQ-025 Samples SHALL never be lost from the circular buffer; the buffer keeps filling during fft_busy.

Reset
REQ-026 While reset is high, at the edge the block SHALL clear to: wr_ptr 0, fill counter 0, hop counter 0, start_fft 0, fft_busy 0, frame_dropped 0, drop_count 0, all frame_out 0, all buffer entries 0; a sample presented with reset high SHALL NOT be accepted, and reset mid-FFT SHALL discard the in-flight frame.

Configuration
REQ-027 Macro FFT_FRAME_OVERLAP_EN SHALL select the hop: defined gives HOP = FFT_POINTS/2 (50% overlap, first frame after FFT_POINTS samples, then every FFT_POINTS/2); undefined gives HOP = FFT_POINTS (no overlap); ordering per REQ-017 SHALL be identical in both.

Verification
REQ-028 The bench SHALL cover fill ordering (macro off): reset, then 16 consecutive valid samples 1..16 -> start_fft high exactly in the cycle after sample 16, and frame_out[0..15] = 1..16.
REQ-029 The bench SHALL cover gapped input: the same 16 samples with sample_valid low every other cycle -> an identical frame, and a single start_fft pulse.
REQ-030 The bench SHALL cover a busy drop: launch, withhold fft_data_valid, then send 16 more samples -> frame_dropped pulses once, drop_count = 1, frame_out still 1..16; pulse fft_data_valid, send 16 more -> the next launch succeeds with samples 33..48.
REQ-031 The bench SHALL cover the simultaneous event: fft_data_valid in the same cycle as a due frame -> a drop, fft_busy low afterward, and the following due frame launches.
REQ-032 The bench SHALL cover overlap (macro on): samples 1..24 -> the first launch gives 1..16, and the second launch, after sample 24, gives 9..24.
REQ-033 The bench SHALL cover reset mid-operation: reset after 10 samples, then samples 100..115 -> a launch with frame_out = 100..115, drop_count 0.
